// File: rtl/fetch_pkg.sv
// Shared types and instruction encodings for the fetch stage.
// Used by instr_fetch_unit and fetch_perf_ctr (FETCH_PERF_EN build).
package fetch_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP          = 32'h0000_0013;
  localparam logic [31:0] INSTR_ILLEGAL_ZERO = 32'h0000_0000;
  localparam logic [31:0] INSTR_ECALL        = 32'h0000_0073;

  function automatic logic is_halt_word(input logic [31:0] word);
    return (word == INSTR_ILLEGAL_ZERO) || (word == INSTR_ECALL);
  endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters: latched-instruction count and bubble count.
// Instantiated by instr_fetch_unit only when FETCH_PERF_EN is defined.
module fetch_perf_ctr
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_inc,
  input  logic        bubble_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (fetch_inc)  fetch_cnt  <= fetch_cnt + 32'd1;
      if (bubble_inc) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, next-PC selection and IF/ID register, with halt on
// illegal-zero/ECALL words. Define FETCH_PERF_EN to add the perf counter outputs.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter int              INS_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [PC_W-1:0]  redirect_pc_i,
  output logic [PC_W-1:0]  imem_ra_o,
  input  logic [INS_W-1:0] imem_rd_i,
  output logic             if_valid_o,
  output logic [INS_W-1:0] if_instr_o,
  output logic [PC_W-1:0]  if_pc_o,
  output logic [PC_W-1:0]  if_pc4_o,
  output logic             halt_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch_cnt_o,
  output logic [31:0]      perf_bubble_cnt_o
`endif
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] redirect_aligned;
  logic            run;
  logic            halt_word;

  assign imem_ra_o        = pc_q;
  assign pc_plus4         = pc_q + PC_STEP;
  assign redirect_aligned = {redirect_pc_i[PC_W-1:2], 2'b00};
  assign run              = (state_q == RUN);
  assign halt_word        = is_halt_word(32'(imem_rd_i));
  assign halt_o           = (state_q == HALT);

  // Redirect beats stall beats normal fetch; HALT freezes everything until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      if_valid_o <= 1'b0;
      if_instr_o <= INS_W'(INSTR_NOP);
      if_pc_o    <= '0;
      if_pc4_o   <= PC_STEP;
    end else if (run) begin
      if (redirect_i) begin
        pc_q       <= redirect_aligned;
        if_valid_o <= 1'b0;
        if_instr_o <= INS_W'(INSTR_NOP);
      end else if (stall_i) begin
        pc_q       <= pc_q;
      end else if (halt_word) begin
        if_valid_o <= 1'b0;
        state_q    <= HALT;
      end else begin
        if_instr_o <= imem_rd_i;
        if_pc_o    <= pc_q;
        if_pc4_o   <= pc_plus4;
        if_valid_o <= 1'b1;
        pc_q       <= pc_plus4;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic fetch_inc;
  logic bubble_inc;

  assign fetch_inc  = run && !redirect_i && !stall_i && !halt_word;
  assign bubble_inc = run && (redirect_i || stall_i);

  fetch_perf_ctr u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_inc  (fetch_inc),
    .bubble_inc (bubble_inc),
    .fetch_cnt  (perf_fetch_cnt_o),
    .bubble_cnt (perf_bubble_cnt_o)
  );
`endif

endmodule
